// File: rtl/switch_debounce5.sv
// Purpose : synchronize, polarity-correct and debounce WIDTH switch/button inputs into a stable vector A with edge strobes.
// Latency : a clean level change sampled at edge k reaches A (and rise/fall/changed) at edge k+1+STABLE_CYCLES.
// Backpress: none; free-running stage, strobes are single-cycle pulses with no handshake.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   raw_in[W-1:0]   - asynchronous switch / pushbutton pins
//   A[W-1:0]        - debounced, polarity-corrected vector (drives the LUT input)
//   rise/fall[W-1:0]- one-cycle pulse per bit when A[i] goes 0->1 / 1->0
//   changed         - one-cycle pulse when any bit of A changes
module switch_debounce5 #(
    parameter int                 WIDTH         = 5,
    parameter int                 STABLE_CYCLES = 250000,
    parameter int                 CNT_W         = 18,
    parameter logic [WIDTH-1:0]   INVERT_MASK   = 5'b10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s0_q, s0_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        // Polarity is fixed before the synchronizer so everything downstream is active-high.
        s0_d   = raw_in ^ INVERT_MASK;
        s1_d   = s0_q;
        a_d    = a_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s1_q[i] == a_q[i]) begin
                // Input agrees with the output: any partial count was bounce.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TERM) begin
                // Counter saturates at the terminal count and is cleared as A follows.
                a_d[i]    = s1_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = s1_q[i];
                fall_d[i] = ~s1_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q      <= '0;
            s1_q      <= '0;
            a_q       <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            a_q       <= a_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign A       = a_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce5.sv
// Purpose : directed-vector bench for switch_debounce5 with a queue scoreboard on the changed strobe.
// Latency : expects A/strobes 5 edges after the sampling edge (STABLE_CYCLES=4).
// Backpress: none; monitor samples every negedge.
module tb_switch_debounce5;

    localparam int W = 5;

    typedef struct {
        int           cyc;
        logic [W-1:0] a;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    // LUT51 truth table: Y=0 for codes {0,5,7,9,12,13,15,16,19,20,26,31}.
    localparam logic [31:0] LUT_INIT = 32'h7BE6_4D5E;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] a;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int   cyc;
    int   n_assert;
    int   n_fail;
    exp_t exp_q[$];
    logic [W-1:0] prev_a;
    logic [W-1:0] model_a;
    logic [31:0]  lut_tab;

    switch_debounce5 #(
        .WIDTH(W),
        .STABLE_CYCLES(4),
        .CNT_W(3),
        .INVERT_MASK(5'b10000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .raw_in(raw_in),
        .A(a),
        .rise(rise),
        .fall(fall),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Advance to just after the n-th next rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new raw value now (just after edge cyc) and record the expected A transition.
    task automatic drive(input logic [W-1:0] raw);
        logic [W-1:0] na;
        exp_t e;
        raw_in = raw;
        na = raw ^ 5'b10000;
        if (na != model_a) begin
            e.cyc  = cyc + 6;
            e.a    = na;
            e.rise = na & ~model_a;
            e.fall = model_a & ~na;
            exp_q.push_back(e);
            model_a = na;
        end
    endtask

    function automatic logic lut_expect(input int code);
        logic y;
        y = 1'b1;
        if (code inside {0, 5, 7, 9, 12, 13, 15, 16, 19, 20, 26, 31}) y = 1'b0;
        return y;
    endfunction

    // Monitor: every strobe must match the next queued expectation at its exact cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_a = a;
        end else begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL missed_change: no changed pulse at cycle %0d, expected A=%b", e.cyc, e.a);
            end
            n_assert++;
            if (!changed && (rise | fall) != '0) begin
                n_fail++;
                $display("FAIL stray_strobe: cycle %0d rise=%b fall=%b with changed=0", cyc, rise, fall);
            end
            n_assert++;
            if (!changed && a != prev_a) begin
                n_fail++;
                $display("FAIL silent_change: cycle %0d A=%b was %b with changed=0", cyc, a, prev_a);
            end
            if (changed) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d A=%b rise=%b fall=%b, none expected", cyc, a, rise, fall);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.a != a || e.rise != rise || e.fall != fall) begin
                        n_fail++;
                        $display("FAIL change_event: got cyc=%0d A=%b rise=%b fall=%b, want cyc=%0d A=%b rise=%b fall=%b",
                                 cyc, a, rise, fall, e.cyc, e.a, e.rise, e.fall);
                    end
                end
            end
            prev_a = a;
        end
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_a  = '0;
        prev_a   = '0;
        lut_tab  = LUT_INIT;
        rst_n    = 1'b0;
        raw_in   = 5'b10000;

        // Reset state before any clock edge.
        #1;
        n_assert++;
        if (a !== 5'b0 || rise !== 5'b0 || fall !== 5'b0 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: A=%b rise=%b fall=%b changed=%b, want all 0", a, rise, fall, changed);
        end
        tick(2);
        rst_n = 1'b1;
        tick(6);

        // Clean step on bit 0.
        drive(5'b10001);
        tick(8);

        // Bounce on bit 1: high 3, low 1, high 2, low -- never accepted.
        raw_in = 5'b10011; tick(3);
        raw_in = 5'b10001; tick(1);
        raw_in = 5'b10011; tick(2);
        raw_in = 5'b10001; tick(8);
        // Then a held high level is accepted.
        drive(5'b10011);
        tick(8);
        // Two bits falling together.
        drive(5'b10000);
        tick(8);

        // Active-low button: press then release.
        drive(5'b00000);
        tick(8);
        drive(5'b10000);
        tick(8);

        // Simultaneous rise on bits 3 and 1.
        drive(5'b11010);
        tick(8);

        // End-to-end through the LUT for every stable code.
        for (int code = 0; code < 32; code++) begin
            logic [W-1:0] cv;
            cv = W'(code);
            drive(cv ^ 5'b10000);
            tick(6);
            n_assert++;
            if (a !== cv || lut_tab[a] !== lut_expect(code)) begin
                n_fail++;
                $display("FAIL lut_code_%0d: A=%b Y=%b, want A=%b Y=%b", code, a, lut_tab[a], cv, lut_expect(code));
            end
            tick(1);
        end

        // Reset mid-count with a non-zero output and raw_in=01111 pending.
        drive(5'b10001);
        tick(8);
        raw_in = 5'b01111;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (a !== 5'b0 || rise !== 5'b0 || fall !== 5'b0 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: A=%b rise=%b fall=%b changed=%b, want all 0", a, rise, fall, changed);
        end
        model_a = '0;
        tick(2);
        rst_n = 1'b1;
        drive(5'b01111);
        tick(10);

        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expected changes never seen, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
